instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Responder end of the instruction-fetch req/gnt/rvalid interface; the fetch stage is the initiator.
- Holds a word-addressed synchronous instruction memory.
- Grants one fetch request at a time and returns 32-bit instruction data after a configurable number of wait states.
- Has a separate loader write port so the bench or boot logic can preload program images.

Parameters:
- ADDR_WIDTH, 12, word-address bits; memory depth = 2**ADDR_WIDTH words of 32 bits.
- WAIT_CYCLES, 0, extra stall cycles between grant and rvalid; legal range 0..15.

Ports:
- clk_i  input  1  clock
- rstn_i  input  1  reset, asynchronous, active-low
- instr_req_i  input  1  fetch request; held by initiator until granted
- instr_addr_i  input  32  byte address of fetch; sampled on grant
- instr_gnt_o  output  1  request accepted this cycle
- instr_rvalid_o  output  1  one-cycle pulse: instr_rdata_o valid
- instr_rdata_o  output  32  fetched instruction word
- load_we_i  input  1  loader write enable
- load_addr_i  input  ADDR_WIDTH  loader word address
- load_wdata_i  input  32  loader write data

Behaviour:
- Clock is clk_i. Reset rstn_i is asynchronous, active-low.
- Reset values:
  - state = IDLE, wait counter = 0.
  - instr_rvalid_o = 0, instr_rdata_o = 32'h0.
  - Captured address = 0.
  - The memory array is not reset.
- FSM states:
  - IDLE: no outstanding request.
  - WAIT: counting stall cycles.
  - RESP: rvalid asserted this cycle.
- Grant rule: instr_gnt_o = instr_req_i & (state==IDLE | state==RESP). Combinational, same cycle as the request.
- On grant:
  - Word index = instr_addr_i[ADDR_WIDTH+1:2] is captured.
  - Address bits [1:0] and bits above ADDR_WIDTH+1 are ignored; the address wraps modulo memory size.
- Transitions:
  - IDLE/RESP + grant, WAIT_CYCLES==0 -> RESP (rvalid on the next cycle: latency 1).
  - IDLE/RESP + grant, WAIT_CYCLES>0 -> WAIT, counter loaded with WAIT_CYCLES-1.
  - WAIT, counter!=0 -> WAIT, counter decrements.
  - WAIT, counter==0 -> RESP.
  - RESP without grant -> IDLE.
  - IDLE without request -> IDLE.
- Total latency from grant edge to rvalid cycle = 1 + WAIT_CYCLES.
- Throughput:
  - WAIT_CYCLES==0: back-to-back, one word per cycle while req is held high.
  - Otherwise one word per (1+WAIT_CYCLES) cycles.
- No grant is given while in WAIT; req is held low-to-high safe.
- Read data:
  - The memory is read on the clock edge entering RESP.
  - instr_rdata_o is registered on that edge and holds its value until the next RESP entry.
- Loader port:
  - When load_we_i is high, the word is written on the clock edge.
  - Write and read to the same word on the same edge: the read returns the OLD contents (read-before-write).
  - The loader may write at any time, including while a fetch is outstanding.
- Wait counter width: 4 bits.
- Reset mid-operation: the outstanding fetch is dropped, no rvalid is produced, and the FSM returns to IDLE.
- instr_rvalid_o is high exactly one cycle per grant; there are never two rvalids for one grant.

Optional Feature:
- Macro: INSTR_MEM_ERR_EN.
- Defined:
  - Adds output port instr_err_o (1 bit, reset 0), asserted together with instr_rvalid_o.
  - Error condition: the captured address had bits [1:0]!=0, or any bit above ADDR_WIDTH+1 set.
  - On error, instr_rdata_o = 32'h0000_0013 (NOP) instead of memory contents.
- Undefined: no instr_err_o port; addresses silently wrap and low bits are ignored, as described above.

Test Plan:
- Basic fetch, WAIT_CYCLES=0:
  - Stimulus: load word 5 = 32'h00A00093, then req with addr 32'h14.
  - Required response: gnt in the same cycle; next cycle rvalid=1 and rdata=32'h00A00093.
- Back-to-back burst, WAIT_CYCLES=0:
  - Stimulus: req held for addrs 0x0, 0x4, 0x8 (preloaded 0x11, 0x22, 0x33).
  - Required response: gnt every cycle; rvalid for 3 consecutive cycles with 0x11, 0x22, 0x33.
- Wait states, WAIT_CYCLES=3:
  - Stimulus: req with addr 0x0 held high.
  - Required response: gnt at cycle 0, no gnt in cycles 1-3, rvalid at cycle 4, next gnt at cycle 4.
- Read/write collision:
  - Stimulus: word 2 = 0xAAAA_AAAA; grant a fetch of 0x8 while load_we_i writes 0xBBBB_BBBB to word 2 on the RESP-entry edge.
  - Required response: rdata=0xAAAA_AAAA; a following fetch of 0x8 returns 0xBBBB_BBBB.
- Reset mid-operation, WAIT_CYCLES=2:
  - Stimulus: fetch granted, rstn_i pulsed low in the WAIT state.
  - Required response: rvalid never asserts; rdata=0; a fresh request is granted immediately after reset release.
- Address wrap and error, ADDR_WIDTH=4:
  - Stimulus: fetch at addr 0x44.
  - Required response without macro: returns word 1.
  - Required response with INSTR_MEM_ERR_EN: instr_err_o=1 with rvalid and rdata=0x00000013; the same applies for addr 0x6.

Source files
------------

// File: rtl/instr_mem_responder_if.sv
// Instruction-fetch req/gnt/rvalid bus between the fetch stage (master) and the memory (slave).
// Defining INSTR_MEM_ERR_EN adds the instr_err_o response flag.
interface instr_mem_responder_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
`ifdef INSTR_MEM_ERR_EN
  logic        instr_err_o;

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
  );

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
  );
`else
  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o
  );

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o
  );
`endif
endinterface

// File: rtl/instr_mem_responder.sv
// Word-addressed instruction memory answering one fetch at a time after WAIT_CYCLES stalls.
// Defining INSTR_MEM_ERR_EN flags misaligned/out-of-range fetches and returns a NOP for them.
module instr_mem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  instr_mem_responder_if.slave  bus,
  input  logic                  load_we_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [31:0]           load_wdata_i
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int          DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t                state, state_next;
  logic [3:0]            wait_cnt, wait_cnt_next;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [ADDR_WIDTH-1:0] read_idx;
  logic [31:0]           rdata;
  logic [31:0]           mem [DEPTH];
  logic                  grant;
  logic                  enter_resp;
  logic                  err_sel;

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    grant         = bus.instr_req_i && ((state == IDLE) || (state == RESP));
    case (state)
      IDLE, RESP: begin
        if (grant) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next    = WAIT;
            wait_cnt_next = WAIT_LOAD;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = RESP;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      word_addr <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (grant) begin
        word_addr <= bus.instr_addr_i[ADDR_WIDTH+1:2];
      end
    end
  end

  // With no wait states RESP is entered on the grant edge itself, so the live address is used.
  assign enter_resp = (state_next == RESP);
  assign read_idx   = grant ? bus.instr_addr_i[ADDR_WIDTH+1:2] : word_addr;

`ifdef INSTR_MEM_ERR_EN
  logic addr_err;
  logic err_cap;
  logic err_q;

  assign addr_err = (bus.instr_addr_i[1:0] != 2'b00) ||
                    ((bus.instr_addr_i >> (ADDR_WIDTH + 2)) != 32'd0);
  assign err_sel  = grant ? addr_err : err_cap;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_cap <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (grant) begin
        err_cap <= addr_err;
      end
      err_q <= enter_resp && err_sel;
    end
  end

  assign bus.instr_err_o = err_q;
`else
  logic addr_unused;

  assign err_sel     = 1'b0;
  assign addr_unused = ^bus.instr_addr_i;
`endif

  // Read data sampled before the loader write lands on the same edge (read-before-write).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdata <= 32'h0;
    end else if (enter_resp) begin
      rdata <= err_sel ? NOP_INSTR : mem[read_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem[load_addr_i] <= load_wdata_i;
    end
  end

  assign bus.instr_gnt_o    = grant;
  assign bus.instr_rvalid_o = (state == RESP);
  assign bus.instr_rdata_o  = rdata;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench: three responders (WAIT_CYCLES 0/3/2) with a grant-to-rvalid scoreboard.
// Honours INSTR_MEM_ERR_EN for the wrap/error expectations.
module tb_instr_mem_responder;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk_i;
  logic        rstn_i;
  logic [2:0]  req, gnt, rvalid, load_we;
  logic [31:0] addr [3];
  logic [31:0] rdata [3];
  logic [11:0] load_addr [3];
  logic [31:0] load_wdata [3];
`ifdef INSTR_MEM_ERR_EN
  logic [2:0]  err;
`endif

  logic [31:0] model [3][4096];
  exp_t        exp_q [3][$];
  int          tests_run;
  int          fail_count;

  instr_mem_responder_if bus0 ();
  instr_mem_responder_if bus1 ();
  instr_mem_responder_if bus2 ();

  assign bus0.instr_req_i  = req[0];
  assign bus0.instr_addr_i = addr[0];
  assign gnt[0]            = bus0.instr_gnt_o;
  assign rvalid[0]         = bus0.instr_rvalid_o;
  assign rdata[0]          = bus0.instr_rdata_o;
  assign bus1.instr_req_i  = req[1];
  assign bus1.instr_addr_i = addr[1];
  assign gnt[1]            = bus1.instr_gnt_o;
  assign rvalid[1]         = bus1.instr_rvalid_o;
  assign rdata[1]          = bus1.instr_rdata_o;
  assign bus2.instr_req_i  = req[2];
  assign bus2.instr_addr_i = addr[2];
  assign gnt[2]            = bus2.instr_gnt_o;
  assign rvalid[2]         = bus2.instr_rvalid_o;
  assign rdata[2]          = bus2.instr_rdata_o;
`ifdef INSTR_MEM_ERR_EN
  assign err[0] = bus0.instr_err_o;
  assign err[1] = bus1.instr_err_o;
  assign err[2] = bus2.instr_err_o;
`endif

  // dut0 is the small 16-word memory so the wrap case is reachable.
  instr_mem_responder #(.ADDR_WIDTH(4), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk_i), .rstn_i(rstn_i), .bus(bus0),
    .load_we_i(load_we[0]), .load_addr_i(load_addr[0][3:0]), .load_wdata_i(load_wdata[0])
  );

  instr_mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) dut1 (
    .clk_i(clk_i), .rstn_i(rstn_i), .bus(bus1),
    .load_we_i(load_we[1]), .load_addr_i(load_addr[1]), .load_wdata_i(load_wdata[1])
  );

  instr_mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut2 (
    .clk_i(clk_i), .rstn_i(rstn_i), .bus(bus2),
    .load_we_i(load_we[2]), .load_addr_i(load_addr[2]), .load_wdata_i(load_wdata[2])
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic int addrWidth(input int i);
    return (i == 0) ? 4 : 12;
  endfunction

  function automatic exp_t predict(input int i, input logic [31:0] a);
    exp_t e;
    int   aw;
    int   idx;
    aw     = addrWidth(i);
    idx    = int'((a >> 2) & ((32'd1 << aw) - 32'd1));
    e.data = model[i][idx];
    e.err  = 1'b0;
`ifdef INSTR_MEM_ERR_EN
    if ((a[1:0] != 2'b00) || ((a >> (aw + 2)) != 32'd0)) begin
      e.data = 32'h0000_0013;
      e.err  = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Responses are popped before new grants are pushed; model writes land after both.
  always @(negedge clk_i) begin
    for (int i = 0; i < 3; i++) begin
      if (rvalid[i]) begin
        checkOutput($sformatf("sb%0d_pending", i), 32'(exp_q[i].size() != 0), 32'd1);
        if (exp_q[i].size() != 0) begin
          exp_t e;
          e = exp_q[i].pop_front();
          checkOutput($sformatf("sb%0d_rdata", i), rdata[i], e.data);
`ifdef INSTR_MEM_ERR_EN
          checkOutput($sformatf("sb%0d_err", i), 32'(err[i]), 32'(e.err));
`endif
        end
      end
      if (gnt[i]) begin
        exp_q[i].push_back(predict(i, addr[i]));
      end
      if (load_we[i]) begin
        model[i][int'(load_addr[i] & 12'((32'd1 << addrWidth(i)) - 32'd1))] = load_wdata[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic applyStimulus(input int i, input logic r, input logic [31:0] a);
    req[i]  = r;
    addr[i] = a;
  endtask

  task automatic loadWord(input int i, input logic [11:0] wa, input logic [31:0] wd);
    load_we[i]    = 1'b1;
    load_addr[i]  = wa;
    load_wdata[i] = wd;
    sample();
    tick();
    load_we[i] = 1'b0;
  endtask

  initial begin
    tests_run  = 0;
    fail_count = 0;
    rstn_i     = 1'b0;
    req        = '0;
    load_we    = '0;
    for (int i = 0; i < 3; i++) begin
      addr[i]       = '0;
      load_addr[i]  = '0;
      load_wdata[i] = '0;
    end

    repeat (2) @(posedge clk_i);
    sample();
    checkOutput("rst_rvalid0", 32'(rvalid[0]), 32'd0);
    checkOutput("rst_rdata0", rdata[0], 32'h0);
    checkOutput("rst_gnt0", 32'(gnt[0]), 32'd0);
    checkOutput("rst_rvalid1", 32'(rvalid[1]), 32'd0);
    tick();
    rstn_i = 1'b1;
    tick();

    // Basic fetch
    loadWord(0, 12'd5, 32'h00A0_0093);
    applyStimulus(0, 1'b1, 32'h14);
    sample();
    checkOutput("basic_gnt", 32'(gnt[0]), 32'd1);
    tick();
    applyStimulus(0, 1'b0, 32'h0);
    sample();
    checkOutput("basic_rvalid", 32'(rvalid[0]), 32'd1);
    checkOutput("basic_rdata", rdata[0], 32'h00A0_0093);
    tick();
    sample();
    checkOutput("basic_rvalid_pulse", 32'(rvalid[0]), 32'd0);
    tick();

    // Back-to-back burst
    loadWord(0, 12'd0, 32'h11);
    loadWord(0, 12'd1, 32'h22);
    loadWord(0, 12'd2, 32'h33);
    applyStimulus(0, 1'b1, 32'h0);
    sample();
    checkOutput("burst_gnt0", 32'(gnt[0]), 32'd1);
    tick();
    applyStimulus(0, 1'b1, 32'h4);
    sample();
    checkOutput("burst_gnt1", 32'(gnt[0]), 32'd1);
    checkOutput("burst_rdata0", rdata[0], 32'h11);
    tick();
    applyStimulus(0, 1'b1, 32'h8);
    sample();
    checkOutput("burst_gnt2", 32'(gnt[0]), 32'd1);
    checkOutput("burst_rdata1", rdata[0], 32'h22);
    tick();
    applyStimulus(0, 1'b0, 32'h0);
    sample();
    checkOutput("burst_rvalid2", 32'(rvalid[0]), 32'd1);
    checkOutput("burst_rdata2", rdata[0], 32'h33);
    tick();
    sample();
    checkOutput("burst_idle", 32'(rvalid[0]), 32'd0);
    tick();

    // Read/write collision on the RESP-entry edge
    loadWord(0, 12'd2, 32'hAAAA_AAAA);
    applyStimulus(0, 1'b1, 32'h8);
    load_we[0]    = 1'b1;
    load_addr[0]  = 12'd2;
    load_wdata[0] = 32'hBBBB_BBBB;
    sample();
    checkOutput("coll_gnt", 32'(gnt[0]), 32'd1);
    tick();
    load_we[0] = 1'b0;
    applyStimulus(0, 1'b0, 32'h0);
    sample();
    checkOutput("coll_old", rdata[0], 32'hAAAA_AAAA);
    tick();
    applyStimulus(0, 1'b1, 32'h8);
    tick();
    applyStimulus(0, 1'b0, 32'h0);
    sample();
    checkOutput("coll_new", rdata[0], 32'hBBBB_BBBB);
    tick();

    // Address wrap / error on the 16-word memory
    loadWord(0, 12'd1, 32'hCAFE_0001);
    applyStimulus(0, 1'b1, 32'h44);
    tick();
    applyStimulus(0, 1'b1, 32'h6);
    sample();
`ifdef INSTR_MEM_ERR_EN
    checkOutput("wrap44_rdata", rdata[0], 32'h0000_0013);
    checkOutput("wrap44_err", 32'(err[0]), 32'd1);
`else
    checkOutput("wrap44_rdata", rdata[0], 32'hCAFE_0001);
`endif
    tick();
    applyStimulus(0, 1'b0, 32'h0);
    sample();
`ifdef INSTR_MEM_ERR_EN
    checkOutput("wrap06_rdata", rdata[0], 32'h0000_0013);
    checkOutput("wrap06_err", 32'(err[0]), 32'd1);
`else
    checkOutput("wrap06_rdata", rdata[0], 32'hCAFE_0001);
`endif
    tick();

    // Wait states, WAIT_CYCLES=3, request held high
    loadWord(1, 12'd0, 32'h1234_5678);
    applyStimulus(1, 1'b1, 32'h0);
    sample();
    checkOutput("wait_gnt_c0", 32'(gnt[1]), 32'd1);
    tick();
    for (int c = 1; c <= 3; c++) begin
      sample();
      checkOutput($sformatf("wait_nogntc%0d", c), 32'(gnt[1]), 32'd0);
      checkOutput($sformatf("wait_norvc%0d", c), 32'(rvalid[1]), 32'd0);
      tick();
    end
    sample();
    checkOutput("wait_rvalid_c4", 32'(rvalid[1]), 32'd1);
    checkOutput("wait_gnt_c4", 32'(gnt[1]), 32'd1);
    checkOutput("wait_rdata_c4", rdata[1], 32'h1234_5678);
    tick();
    applyStimulus(1, 1'b0, 32'h0);
    for (int c = 5; c <= 7; c++) begin
      sample();
      checkOutput($sformatf("wait_norvc%0d", c), 32'(rvalid[1]), 32'd0);
      tick();
    end
    sample();
    checkOutput("wait_rvalid_c8", 32'(rvalid[1]), 32'd1);
    tick();

    // Reset mid-operation, WAIT_CYCLES=2
    loadWord(2, 12'd3, 32'h0BAD_F00D);
    applyStimulus(2, 1'b1, 32'hC);
    sample();
    checkOutput("rstmid_gnt", 32'(gnt[2]), 32'd1);
    tick();
    applyStimulus(2, 1'b0, 32'h0);
    sample();
    checkOutput("rstmid_wait", 32'(rvalid[2]), 32'd0);
    rstn_i = 1'b0;
    for (int i = 0; i < 3; i++) exp_q[i].delete();
    #1;
    checkOutput("rstmid_rvalid", 32'(rvalid[2]), 32'd0);
    checkOutput("rstmid_rdata2", rdata[2], 32'h0);
    checkOutput("rstmid_rdata0", rdata[0], 32'h0);
    tick();
    sample();
    checkOutput("rstmid_hold", 32'(rvalid[2]), 32'd0);
    tick();
    rstn_i = 1'b1;
    applyStimulus(2, 1'b1, 32'hC);
    sample();
    checkOutput("rstmid_regnt", 32'(gnt[2]), 32'd1);
    tick();
    applyStimulus(2, 1'b0, 32'h0);
    for (int c = 1; c <= 2; c++) begin
      sample();
      checkOutput($sformatf("rstmid_norv%0d", c), 32'(rvalid[2]), 32'd0);
      tick();
    end
    sample();
    checkOutput("rstmid_rvalid_new", 32'(rvalid[2]), 32'd1);
    checkOutput("rstmid_rdata_new", rdata[2], 32'h0BAD_F00D);
    tick();
    repeat (2) tick();

    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("drain%0d", i), 32'(exp_q[i].size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
